// File: rtl/spi_slave_burst.sv
// spi_slave_burst
//   SPI slave front end. Shifts in framed command/address/data words, hands
//   each completed frame to the memory side with a one-cycle rx_valid pulse,
//   and returns read data as a burst of BURST_LEN words of DATA_W bits on MISO.
//
//   Frame: SS_n low, one mode bit (0 = write, 1 = read), then DATA_W+2 payload
//   bits, MSB first. The first read frame carries the address and arms
//   rd_addr_pending. The next read frame is the data request: after its
//   payload, the slave streams the burst.
//
// Parameters
//   DATA_W    : width of one tx word; the rx payload is DATA_W+2 bits
//   BURST_LEN : tx words per data request (>= 1)
//   MISO_IDLE : MISO level whenever no tx bit is being shifted
//
// Ports
//   clk       in   serial clock, rising-edge sampling
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   slave select, active low; high aborts or ends a frame
//   MOSI      in   serial data in, MSB first
//   tx_valid  in   tx_data is ready (only looked at while waiting for a word)
//   tx_data   in   read word from the memory side
//   MISO      out  serial data out, MSB first
//   rx_valid  out  one-cycle pulse, rx_data holds a new frame
//   rx_data   out  last completed frame payload
//   busy      out  high whenever the slave is not idle
//   frame_err out  (only with SPI_FRAME_ERR_EN) one-cycle pulse when a frame is
//                  cut short mid-payload or mid-word
//
// Build option
//   SPI_FRAME_ERR_EN : adds the frame_err output.

module spi_slave_burst #(
    parameter int   DATA_W    = 8,
    parameter int   BURST_LEN = 1,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
`ifdef SPI_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam int RX_W    = DATA_W + 2;
    localparam int BIT_CW  = $clog2(RX_W) + 1;
    localparam int WORD_CW = $clog2(BURST_LEN) + 1;

    localparam logic [BIT_CW-1:0]  LAST_RX   = BIT_CW'(RX_W - 1);
    localparam logic [BIT_CW-1:0]  LAST_TX   = BIT_CW'(DATA_W - 1);
    localparam logic [WORD_CW-1:0] BURST_CNT = WORD_CW'(BURST_LEN);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;
    localparam logic [2:0] READ_WAIT = 3'd5;
    localparam logic [2:0] READ_TX   = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]         state;
    logic [RX_W-2:0]    rx_shift;   // the newest bit comes straight from MOSI
    logic [DATA_W-1:0]  tx_shift;
    logic [BIT_CW-1:0]  bit_cnt;
    logic [WORD_CW-1:0] word_cnt;
    logic [WORD_CW-1:0] word_next;
    logic               rd_addr_pending;

    assign word_next = word_cnt + WORD_CW'(1);
    assign busy      = (state != IDLE);
    assign MISO      = (state == READ_TX) ? tx_shift[DATA_W-1] : MISO_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rx_shift        <= '0;
            rx_data         <= '0;
            rx_valid        <= 1'b0;
            tx_shift        <= '0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            rd_addr_pending <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    if (!SS_n) begin
                        state <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    bit_cnt <= '0;
                    if (SS_n) begin
                        state <= IDLE;
                    end else if (!MOSI) begin
                        state <= WRITE;
                    end else if (rd_addr_pending) begin
                        state <= READ_DATA;
                    end else begin
                        state <= READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    rx_shift <= {rx_shift[RX_W-3:0], MOSI};
                    // The last bit is taken even if SS_n rises on that edge.
                    if (bit_cnt == LAST_RX) begin
                        rx_data  <= {rx_shift, MOSI};
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        if (state == READ_ADD) begin
                            rd_addr_pending <= 1'b1;
                        end
                        if (SS_n) begin
                            state <= IDLE;
                        end else if (state == READ_DATA) begin
                            state <= READ_WAIT;
                        end else begin
                            state <= DONE;
                        end
                    end else if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                    end
                end

                READ_WAIT: begin
                    if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else if (tx_valid) begin
                        tx_shift <= tx_data;
                        bit_cnt  <= '0;
                        state    <= READ_TX;
                    end
                end

                READ_TX: begin
                    // An aborted burst keeps rd_addr_pending so it can be retried.
                    if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        if (bit_cnt == LAST_TX) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_next;
                            if (word_next < BURST_CNT) begin
                                state <= READ_WAIT;
                            end else begin
                                rd_addr_pending <= 1'b0;
                                state           <= DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CW'(1);
                        end
                    end
                end

                DONE: begin
                    if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_EN
    // Only aborts that cut a payload or a tx word short count as errors.
    logic abort_mid;
    assign abort_mid = SS_n &&
        ((((state == WRITE) || (state == READ_ADD) || (state == READ_DATA)) &&
          (bit_cnt != LAST_RX)) ||
         (state == READ_TX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort_mid;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_burst.sv
// tb_spi_slave_burst
//   Directed bench for spi_slave_burst. Two instances share every input:
//   dut1 is built with BURST_LEN=1 and dut3 with BURST_LEN=3. Both see the
//   same frames, so their read-address state stays in step.

module tb_spi_slave_burst;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic       miso1, rx_valid1, busy1;
    logic [9:0] rx_data1;
    logic       miso3, rx_valid3, busy3;
    logic [9:0] rx_data3;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err1, frame_err3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_slave_burst #(.DATA_W(8), .BURST_LEN(1), .MISO_IDLE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
        .tx_valid(tx_valid), .tx_data(tx_data), .MISO(miso1),
        .rx_valid(rx_valid1), .rx_data(rx_data1),
`ifdef SPI_FRAME_ERR_EN
        .frame_err(frame_err1),
`endif
        .busy(busy1)
    );

    spi_slave_burst #(.DATA_W(8), .BURST_LEN(3), .MISO_IDLE(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
        .tx_valid(tx_valid), .tx_data(tx_data), .MISO(miso3),
        .rx_valid(rx_valid3), .rx_data(rx_data3),
`ifdef SPI_FRAME_ERR_EN
        .frame_err(frame_err3),
`endif
        .busy(busy3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    // One full frame: SS_n low, mode bit, 10 payload bits. Optionally raises
    // SS_n together with the last payload bit. Counts rx_valid seen mid-frame.
    task automatic applyStimulus(input logic mode, input logic [9:0] payload,
                                 input logic ssAtLast, output int pulses);
        pulses = 0;
        ss_n = 1'b0;
        tick();
        mosi = mode;
        tick();
        for (int i = 9; i >= 0; i--) begin
            mosi = payload[i];
            if (i == 0 && ssAtLast) ss_n = 1'b1;
            if (rx_valid1) pulses++;
            tick();
        end
        mosi = 1'b0;
    endtask

    task endFrame;
        ss_n = 1'b1;
        tick();
    endtask

    // Waits `delay` cycles in READ_WAIT, offers one word, then collects 8 bits.
    task automatic readWord(input int delay, input logic [7:0] data,
                            output logic [7:0] got1, output logic [7:0] got3);
        for (int d = 0; d < delay; d++) begin
            checkOutput("miso_wait", 32'(miso3), 32'd0);
            tx_valid = 1'b0;
            tick();
        end
        tx_valid = 1'b1;
        tx_data  = data;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~data;
        for (int i = 7; i >= 0; i--) begin
            got1[i] = miso1;
            got3[i] = miso3;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         p;
        logic [7:0] g1, g3;

        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #12;
        checkOutput("rst_rx_data", 32'(rx_data1), 32'h0);
        checkOutput("rst_rx_valid", 32'(rx_valid1), 32'd0);
        checkOutput("rst_miso", 32'(miso1), 32'd0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        checkOutput("rst_frame_err", 32'(frame_err1), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Write frame
        applyStimulus(1'b0, 10'h0A5, 1'b0, p);
        checkOutput("wr_early_valid", 32'(p), 32'd0);
        checkOutput("wr_rx_valid", 32'(rx_valid1), 32'd1);
        checkOutput("wr_rx_data", 32'(rx_data1), 32'h0A5);
        tick();
        checkOutput("wr_valid_drop", 32'(rx_valid1), 32'd0);
        checkOutput("wr_done_busy", 32'(busy1), 32'd1);
        endFrame();
        checkOutput("wr_idle", 32'(busy1), 32'd0);

        // Abort a write after 4 payload bits
        ss_n = 1'b0; tick();
        mosi = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            tick();
        end
        ss_n = 1'b1;
        tick();
        checkOutput("ab_rx_valid", 32'(rx_valid1), 32'd0);
        checkOutput("ab_rx_data", 32'(rx_data1), 32'h0A5);
        checkOutput("ab_idle", 32'(busy1), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        checkOutput("ab_frame_err", 32'(frame_err1), 32'd1);
`endif
        tick();
`ifdef SPI_FRAME_ERR_EN
        checkOutput("ab_frame_err_drop", 32'(frame_err1), 32'd0);
`endif
        mosi = 1'b0;

        // SS_n rises together with the last payload bit
        applyStimulus(1'b0, 10'h2F0, 1'b1, p);
        checkOutput("last_rx_valid", 32'(rx_valid1), 32'd1);
        checkOutput("last_rx_data", 32'(rx_data1), 32'h2F0);
        checkOutput("last_idle", 32'(busy1), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        checkOutput("last_no_err", 32'(frame_err1), 32'd0);
`endif
        tick();
        checkOutput("last_valid_drop", 32'(rx_valid1), 32'd0);

        // Read address, then read data with BURST_LEN=1 (dut3 finishes its burst)
        applyStimulus(1'b1, 10'h1C3, 1'b0, p);
        checkOutput("ra_rx_data1", 32'(rx_data1), 32'h1C3);
        checkOutput("ra_rx_data3", 32'(rx_data3), 32'h1C3);
        endFrame();
        applyStimulus(1'b1, 10'h300, 1'b0, p);
        checkOutput("rd_rx_data", 32'(rx_data1), 32'h300);
        checkOutput("rd_wait_miso", 32'(miso1), 32'd0);
        readWord(0, 8'h5A, g1, g3);
        checkOutput("rd1_word", 32'(g1), 32'h5A);
        checkOutput("rd3_word0", 32'(g3), 32'h5A);
        checkOutput("rd1_done_busy", 32'(busy1), 32'd1);
        checkOutput("rd1_done_miso", 32'(miso1), 32'd0);
        readWord(0, 8'h00, g1, g3);
        checkOutput("rd3_word1", 32'(g3), 32'h00);
        readWord(0, 8'h81, g1, g3);
        checkOutput("rd3_word2", 32'(g3), 32'h81);
        endFrame();

        // Pending must be clear: a mode-1 frame is an address again
        applyStimulus(1'b1, 10'h011, 1'b0, p);
        tx_valid = 1'b1; tx_data = 8'hA5;
        tick();
        checkOutput("clr1_miso", 32'(miso1), 32'd0);
        checkOutput("clr3_miso", 32'(miso3), 32'd0);
        checkOutput("clr1_busy", 32'(busy1), 32'd1);
        tx_valid = 1'b0;
        endFrame();

        // Burst of three with tx_valid delays 0, 2, 5
        applyStimulus(1'b1, 10'h3FF, 1'b0, p);
        readWord(0, 8'hFF, g1, g3);
        checkOutput("b1_word0", 32'(g1), 32'hFF);
        checkOutput("b3_word0", 32'(g3), 32'hFF);
        readWord(2, 8'h00, g1, g3);
        checkOutput("b3_word1", 32'(g3), 32'h00);
        readWord(5, 8'h81, g1, g3);
        checkOutput("b3_word2", 32'(g3), 32'h81);
        tx_valid = 1'b1; tx_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("b3_no_extra", 32'(miso3), 32'd0);
            tick();
        end
        checkOutput("b3_done_busy", 32'(busy3), 32'd1);
        tx_valid = 1'b0;
        endFrame();

        // Abort during READ_TX after 3 bits, then retry the data frame
        applyStimulus(1'b1, 10'h0F0, 1'b0, p);
        endFrame();
        applyStimulus(1'b1, 10'h301, 1'b0, p);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        checkOutput("tx_ab_before", 32'(miso1), 32'd1);
        ss_n = 1'b1;
        tick();
        checkOutput("tx_ab_miso1", 32'(miso1), 32'd0);
        checkOutput("tx_ab_miso3", 32'(miso3), 32'd0);
        checkOutput("tx_ab_idle", 32'(busy1), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        checkOutput("tx_ab_frame_err", 32'(frame_err1), 32'd1);
`endif
        applyStimulus(1'b1, 10'h302, 1'b0, p);
        readWord(1, 8'h96, g1, g3);
        checkOutput("retry1_word", 32'(g1), 32'h96);
        checkOutput("retry3_word", 32'(g3), 32'h96);
        readWord(0, 8'h3C, g1, g3);
        readWord(0, 8'hC3, g1, g3);
        checkOutput("retry3_last", 32'(g3), 32'hC3);
        endFrame();

        // Reset in the middle of READ_TX
        applyStimulus(1'b1, 10'h010, 1'b0, p);
        endFrame();
        applyStimulus(1'b1, 10'h020, 1'b0, p);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick();
        checkOutput("rst_tx_before", 32'(miso1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_miso1", 32'(miso1), 32'd0);
        checkOutput("arst_miso3", 32'(miso3), 32'd0);
        checkOutput("arst_busy1", 32'(busy1), 32'd0);
        checkOutput("arst_busy3", 32'(busy3), 32'd0);
        checkOutput("arst_rx_valid", 32'(rx_valid1), 32'd0);
        checkOutput("arst_rx_data", 32'(rx_data1), 32'h0);
        ss_n = 1'b1;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 10'h055, 1'b0, p);
        checkOutput("post_rst_rx_data", 32'(rx_data1), 32'h055);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tick();
        checkOutput("post_rst_miso1", 32'(miso1), 32'd0);
        checkOutput("post_rst_miso3", 32'(miso3), 32'd0);
        checkOutput("post_rst_busy", 32'(busy1), 32'd1);
        tx_valid = 1'b0;
        endFrame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
